// File: rtl/floppy_sd_arbiter.sv
// floppy_sd_arbiter
// Shares one SD host block port between N floppy track-buffer clients.
// One client is granted per 512-byte sector transfer in round-robin order;
// ack, buffer write strobes and write data are routed to that client only.
// sd_buff_addr and sd_buff_dout fan out at the top level and never pass here.

module floppy_sd_arbiter #(
  parameter int N = 2  // number of clients, 1..4
) (
  input  logic            clk,
  input  logic            reset,
  // client side
  input  logic [32*N-1:0] cl_lba,
  input  logic [N-1:0]    cl_rd,
  input  logic [N-1:0]    cl_wr,
  output logic [N-1:0]    cl_ack,
  input  logic [8*N-1:0]  cl_buff_din,
  output logic [N-1:0]    cl_buff_wr,
  // host side
  output logic [31:0]     sd_lba,
  output logic            sd_rd,
  output logic            sd_wr,
  input  logic            sd_ack,
  input  logic            sd_buff_wr,
  output logic [7:0]      sd_buff_din,
  // status
  output logic            sd_busy,
  output logic [1:0]      gnt_idx
);

  // Arbiter states
  localparam logic [1:0] ST_IDLE    = 2'd0;  // searching for a pending client
  localparam logic [1:0] ST_ISSUE   = 2'd1;  // request asserted, waiting for ack
  localparam logic [1:0] ST_XFER    = 2'd2;  // host is moving the sector
  localparam logic [1:0] ST_RELEASE = 2'd3;  // one-cycle gap so the client sees ack fall

  localparam logic [1:0] LAST_IDX = 2'(N - 1);

  logic [1:0]   state;
  logic [1:0]   rr;          // first client examined by the next search
  logic [N-1:0] pending;
  logic         win_found;
  logic [1:0]   win_idx;
  logic [1:0]   cand;
  logic [31:0]  win_lba;
  logic         win_wr;
  logic [1:0]   rr_next;
  logic         granted;

  // (base + off) mod N, where base < N and off < N
  function automatic logic [1:0] wrap_add(input logic [1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return 2'(sum);
  endfunction

  // Round-robin search: first pending client at or after rr wins
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pending   = cl_rd | cl_wr;
    win_found = 1'b0;
    win_idx   = rr;
    cand      = rr;
    for (int k = 0; k < N; k++) begin
      cand = wrap_add(rr, k);
      for (int i = 0; i < N; i++) begin
        if (!win_found && (cand == 2'(i)) && pending[i]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // Winner's LBA, direction and the pointer value following it
  always_comb begin
    win_lba = '0;
    win_wr  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == 2'(i)) begin
        win_lba = cl_lba[32*i +: 32];
        win_wr  = cl_wr[i];
      end
    end
    rr_next = (win_idx == LAST_IDX) ? 2'd0 : win_idx + 2'd1;
  end

  // Grant FSM plus the registered host-side request, LBA and grant index
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other, independent of statement order.
    if (reset) begin
      state   <= ST_IDLE;
      rr      <= 2'd0;
      gnt_idx <= 2'd0;
      sd_lba  <= 32'd0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            gnt_idx <= win_idx;
            sd_lba  <= win_lba;
            // a client asking for both directions is served as a write
            sd_wr   <= win_wr;
            sd_rd   <= ~win_wr;
            rr      <= rr_next;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!sd_ack) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Route ack, buffer strobe and write data to the granted client only
  always_comb begin
    granted     = (state == ST_ISSUE) || (state == ST_XFER);
    cl_ack      = '0;
    cl_buff_wr  = '0;
    sd_buff_din = 8'd0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == 2'(i)) begin
        cl_ack[i]     = sd_ack & granted;
        cl_buff_wr[i] = sd_buff_wr & granted;
        sd_buff_din   = cl_buff_din[8*i +: 8];
      end
    end
  end

  assign sd_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_floppy_sd_arbiter.sv
// Self-checking bench for floppy_sd_arbiter: directed sector scenarios with
// literal expectations, then randomized clients/host, all outputs compared
// every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps

module tb_floppy_sd_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [32*N-1:0] cl_lba;
  logic [N-1:0]    cl_rd, cl_wr, cl_ack, cl_buff_wr;
  logic [8*N-1:0]  cl_buff_din;
  logic [31:0]     sd_lba;
  logic            sd_rd, sd_wr, sd_ack, sd_buff_wr, sd_busy;
  logic [7:0]      sd_buff_din;
  logic [1:0]      gnt_idx;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  floppy_sd_arbiter #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .cl_lba      (cl_lba),
    .cl_rd       (cl_rd),
    .cl_wr       (cl_wr),
    .cl_ack      (cl_ack),
    .cl_buff_din (cl_buff_din),
    .cl_buff_wr  (cl_buff_wr),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .sd_busy     (sd_busy),
    .gnt_idx     (gnt_idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A sector grant is a record: who owns it, what LBA/direction was latched,
  // whether the host has acknowledged yet, and whether the post-sector gap
  // is still pending.
  bit          m_active  = 1'b0;
  bit          m_acked   = 1'b0;
  bit          m_release = 1'b0;
  bit          m_is_wr   = 1'b0;
  int          m_owner   = 0;
  int          m_rr      = 0;
  int          m_grants  = 0;
  logic [31:0] m_lba     = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_acked = 1'b0; m_release = 1'b0; m_is_wr = 1'b0;
      m_owner = 0; m_rr = 0; m_lba = '0;
    end else if (m_release) begin
      m_release = 1'b0;
    end else if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        if (!m_active && (cl_rd[(m_rr + k) % N] || cl_wr[(m_rr + k) % N])) begin
          m_owner  = (m_rr + k) % N;
          m_lba    = cl_lba[32*m_owner +: 32];
          m_is_wr  = cl_wr[m_owner];
          m_acked  = 1'b0;
          m_active = 1'b1;
        end
      end
      if (m_active) begin
        m_rr = (m_owner + 1) % N;
        m_grants++;
      end
    end else if (!m_acked) begin
      if (sd_ack) m_acked = 1'b1;
    end else if (!sd_ack) begin
      m_active  = 1'b0;
      m_release = 1'b1;
    end
  end

  logic [N-1:0] e_ack, e_bwr;
  logic [7:0]   e_din;

  // compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_ack[i] = sd_ack && m_active && (m_owner == i);
        e_bwr[i] = sd_buff_wr && m_active && (m_owner == i);
      end
      e_din = cl_buff_din[8*m_owner +: 8];
      check("m_sd_rd",       sd_rd,       m_active && !m_acked && !m_is_wr);
      check("m_sd_wr",       sd_wr,       m_active && !m_acked && m_is_wr);
      check("m_sd_lba",      sd_lba,      m_lba);
      check("m_gnt_idx",     gnt_idx,     m_owner);
      check("m_sd_busy",     sd_busy,     m_active || m_release);
      check("m_cl_ack",      cl_ack,      e_ack);
      check("m_cl_buff_wr",  cl_buff_wr,  e_bwr);
      check("m_sd_buff_din", sd_buff_din, e_din);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cl_rd = '0; cl_wr = '0; cl_lba = '0; cl_buff_din = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // wait (bounded) for the host request; returns at the negedge it is seen
  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sd_rd || sd_wr) ok = 1'b1;
      else tick();
    end
    check("req_seen", ok, 1'b1);
  endtask

  // host acks the issued request for ack_len cycles; clients in drop withdraw
  task automatic finish_sector(input int ack_len, input logic [N-1:0] drop);
    tick();
    sd_ack = 1'b1;
    tick();
    cl_rd = cl_rd & ~drop;
    cl_wr = cl_wr & ~drop;
    repeat (ack_len - 1) tick();
    sd_ack = 1'b0;
    tick();
    tick();
  endtask

  int          exp_g[4] = '{0, 1, 0, 1};
  logic [31:0] exp_l[4] = '{32'd0, 32'd13, 32'd0, 32'd13};
  int          pulses;
  logic        pulse;
  int          r;

  initial begin
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // reset state
    @(negedge clk);
    check("rst_sd_rd", sd_rd, 1'b0);
    check("rst_sd_wr", sd_wr, 1'b0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_gnt_idx", gnt_idx, 2'd0);
    check("rst_busy", sd_busy, 1'b0);
    check("rst_cl_ack", cl_ack, 2'b00);
    tick();

    // single read from client 0
    cl_lba[31:0] = 32'h1A;
    cl_rd[0] = 1'b1;
    tick();
    @(negedge clk);
    check("rd_sd_rd", sd_rd, 1'b1);
    check("rd_sd_lba", sd_lba, 32'h1A);
    tick();
    sd_ack = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      pulse = (c == 2) || (c == 5) || (c == 8);
      sd_buff_wr = pulse;
      if (c == 1) cl_rd[0] = 1'b0;
      @(negedge clk);
      check("rd_cl_ack", cl_ack, 2'b01);
      check("rd_cl_buff_wr", cl_buff_wr, pulse ? 2'b01 : 2'b00);
      if (cl_buff_wr[0]) pulses++;
      tick();
    end
    check("rd_pulses", pulses, 3);
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    @(negedge clk);
    check("rd_busy_release", sd_busy, 1'b1);
    tick();
    @(negedge clk);
    check("rd_busy_fall", sd_busy, 1'b0);
    tick();

    // round-robin with both clients requesting continuously
    do_reset();
    cl_lba = {32'd13, 32'd0};
    cl_rd = 2'b11;
    for (int s = 0; s < 4; s++) begin
      wait_req();
      check("rr_gnt", gnt_idx, exp_g[s]);
      check("rr_lba", sd_lba, exp_l[s]);
      finish_sector(3, 2'b00);
    end
    cl_rd = 2'b00;
    tick();
    tick();

    // write priority and data mux
    do_reset();
    cl_rd[1] = 1'b1;
    cl_wr[1] = 1'b1;
    cl_buff_din = {8'hA5, 8'h3C};
    wait_req();
    check("wp_sd_wr", sd_wr, 1'b1);
    check("wp_sd_rd", sd_rd, 1'b0);
    check("wp_gnt", gnt_idx, 2'd1);
    tick();
    sd_ack = 1'b1;
    tick();
    @(negedge clk);
    check("wp_din", sd_buff_din, 8'hA5);
    check("wp_cl_ack", cl_ack, 2'b10);
    tick();
    cl_rd = 2'b00;
    cl_wr = 2'b00;
    sd_ack = 1'b0;
    tick();
    tick();

    // late LBA change is ignored until the next grant
    cl_lba[31:0] = 32'd5;
    cl_rd[0] = 1'b1;
    wait_req();
    check("late_lba_issue", sd_lba, 32'd5);
    tick();
    sd_ack = 1'b1;
    tick();
    cl_lba[31:0] = 32'd9;
    cl_rd[0] = 1'b0;
    @(negedge clk);
    check("late_lba_xfer", sd_lba, 32'd5);
    tick();
    sd_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("late_lba_idle", sd_lba, 32'd5);
    check("late_busy_idle", sd_busy, 1'b0);
    tick();
    cl_rd[0] = 1'b1;
    wait_req();
    check("late_lba_next", sd_lba, 32'd9);
    finish_sector(2, 2'b01);

    // client 1 request dropped before the release gap ends
    cl_lba[31:0] = 32'h77;
    cl_rd[0] = 1'b1;
    wait_req();
    check("drop_gnt", gnt_idx, 2'd0);
    tick();
    sd_ack = 1'b1;
    tick();
    cl_rd[1] = 1'b1;
    cl_rd[0] = 1'b0;
    tick();
    sd_ack = 1'b0;
    tick();
    cl_rd[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("drop_no_regrant", sd_rd, 1'b0);
      tick();
    end
    @(negedge clk);
    check("drop_idle", sd_busy, 1'b0);
    tick();

    // asynchronous reset in the middle of a transfer
    cl_rd[0] = 1'b1;
    wait_req();
    tick();
    sd_ack = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_sd_rd", sd_rd, 1'b0);
    check("arst_sd_wr", sd_wr, 1'b0);
    check("arst_busy", sd_busy, 1'b0);
    check("arst_cl_ack", cl_ack, 2'b00);
    clear_inputs();
    tick();
    reset = 1'b0;
    cl_lba[63:32] = 32'h2B;
    cl_rd[1] = 1'b1;
    wait_req();
    check("arst_regrant", gnt_idx, 2'd1);
    check("arst_regrant_rd", sd_rd, 1'b1);
    check("arst_regrant_lba", sd_lba, 32'h2B);
    finish_sector(2, 2'b10);

    // randomized clients and host
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (cl_rd[i] || cl_wr[i]) begin
          if (cl_ack[i] && $urandom_range(0, 3) != 0) begin
            cl_rd[i] = 1'b0;
            cl_wr[i] = 1'b0;
          end else if ($urandom_range(0, 49) == 0) begin
            cl_rd[i] = 1'b0;
            cl_wr[i] = 1'b0;
          end
          if ($urandom_range(0, 9) == 0) cl_lba[32*i +: 32] = $urandom;
        end else if ($urandom_range(0, 3) == 0) begin
          r = int'($urandom_range(1, 3));
          cl_rd[i] = r[0];
          cl_wr[i] = r[1];
          cl_lba[32*i +: 32] = $urandom;
        end
        cl_buff_din[8*i +: 8] = 8'($urandom);
      end
      if (sd_ack) begin
        if ($urandom_range(0, 4) == 0) sd_ack = 1'b0;
      end else if ((sd_rd || sd_wr) && $urandom_range(0, 1) == 0) begin
        sd_ack = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        sd_ack = 1'b1;
      end
      sd_buff_wr = sd_ack && ($urandom_range(0, 1) == 1);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    tick();
    check("rand_grants_seen", (m_grants > 20) ? 1'b1 : 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/floppy_sd_arbiter.md
# floppy_sd_arbiter

Shares one SD host block port (lba/rd/wr/ack plus sector buffer bus) between N floppy track-buffer units, one per drive. Each client raises a level read or write request with an LBA. The arbiter grants one client per 512-byte sector transfer in round-robin order and routes ack and buffer traffic to the granted client only. It sits between the drive track units and the top-level SD/HPS block interface.

## Interface
- `N`, default 2: number of clients (1..4).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `cl_lba`  in  32*N  per-client sector LBA; client i occupies bits [32i+31:32i].
- `cl_rd`  in  N  per-client read request; level, held until that client sees ack.
- `cl_wr`  in  N  per-client write request; level, held until that client sees ack.
- `cl_ack`  out  N  per-client ack; equals `sd_ack` for the granted client, 0 for all others.
- `cl_buff_din`  in  8*N  per-client sector data toward the host (write path).
- `cl_buff_wr`  out  N  per-client buffer write strobe (read path).
- `sd_lba`  out  32  LBA presented to the host.
- `sd_rd`  out  1  read request to the host.
- `sd_wr`  out  1  write request to the host.
- `sd_ack`  in  1  host transfer-in-progress acknowledge.
- `sd_buff_wr`  in  1  host buffer write strobe.
- `sd_buff_din`  out  8  muxed write data from the granted client.
- `sd_busy`  out  1  high whenever the arbiter state is not IDLE.
- `gnt_idx`  out  2  index of the current or most recent grant (debug and status).

## Operation
- States: IDLE, ISSUE, XFER, RELEASE.
- **IDLE:** a client is pending when `cl_rd[i] | cl_wr[i]`.
  - Search starts at pointer `rr` and proceeds rr, rr+1, …, wrapping mod N. The first pending client wins.
  - On a win, register: `gnt_idx`, `sd_lba` ← that client's `cl_lba`, and direction.
  - If `cl_wr[i]` is set, assert `sd_wr`. Otherwise assert `sd_rd`. Write wins when both are set.
  - Move to ISSUE. Set `rr` ← winner+1 mod N.
- **ISSUE:** hold `sd_rd`/`sd_wr` and `sd_lba`. When `sd_ack` is high, clear `sd_rd`/`sd_wr` in the same edge and move to XFER.
- **XFER:** hold the grant and stay here while `sd_ack` is high. On the first low `sd_ack`, move to RELEASE.
- **RELEASE:** one cycle with no grant. This lets the client see ack fall and re-raise its next-sector request. Then move to IDLE.
- Grant routing, combinational:
  - Let `g` = (state is ISSUE or XFER).
  - `cl_ack[i]` = `sd_ack & g & (gnt_idx == i)`.
  - `cl_buff_wr[i]` = `sd_buff_wr & g & (gnt_idx == i)`.
  - `sd_buff_din` = `cl_buff_din[gnt_idx]`.
  - `sd_buff_addr` and `sd_buff_dout` fan out directly at the top level. The arbiter does not touch them.
- Request and LBA are sampled only in IDLE. Changes to `cl_lba`, `cl_rd`, or `cl_wr` while granted are ignored.
- If a client drops its request before it is granted, it is never served.
- If the granted client drops its request after issue, the transfer still completes.
- Clients with index ≥ N do not exist. `rr` stays in 0..N-1.

## Timing
- Reset (asynchronous) values: state = IDLE, `sd_rd` = 0, `sd_wr` = 0, `sd_lba` = 0, `gnt_idx` = 0, `rr` = 0, `sd_busy` = 0. All `cl_ack` and `cl_buff_wr` are 0.
- Request latency: pending request sampled at edge k in IDLE → `sd_rd`/`sd_wr` high after edge k.
- `sd_rd`/`sd_wr` fall on the edge that samples `sd_ack` = 1. They are never high for more than one cycle past the ack rise.
- Ack-fall overhead: `sd_ack` sampled low at edge m → RELEASE during m..m+1 → IDLE after m+1. The next grant is issued after edge m+2.
- Routed `cl_ack` and `cl_buff_wr` have zero added latency (combinational).
- Reset mid-transfer: outputs return to reset values immediately. Host-side recovery is the host's responsibility.
- N = 1 degenerates to pass-through plus the RELEASE bubble.

## Test plan
- **Single read:** N=2. Client 0 `cl_rd`=1, `cl_lba`=0x1A. Expect `sd_rd`=1 and `sd_lba`=0x1A one cycle later. Ack high for 10 cycles: `cl_ack[0]` mirrors it and `cl_ack[1]`=0. 3 `sd_buff_wr` pulses appear only on `cl_buff_wr[0]`. `sd_busy` falls 2 cycles after ack fall.
- **Round-robin:** both clients hold `cl_rd` continuously with LBAs 0 and 13. Grants alternate 0,1,0,1 over 4 sectors, and `sd_lba` alternates 0,13.
- **Write priority and data mux:** client 1 raises `cl_rd` and `cl_wr` together with `cl_buff_din[1]`=0xA5. Expect `sd_wr`=1, `sd_rd`=0, and `sd_buff_din`=0xA5 during ack.
- **Late LBA change:** client 0 changes `cl_lba` from 5 to 9 during XFER. `sd_lba` stays 5 until the next grant.
- **Dropped request:** client 1 raises `cl_rd` while client 0 is in XFER, then drops it before RELEASE ends. No second grant occurs and the arbiter returns to IDLE.
- **Async reset:** assert `reset` mid-XFER between clock edges. `sd_rd`, `sd_wr`, `sd_busy` and all `cl_ack` are 0 immediately. After release, a fresh client-1 request is granted normally with `rr`=0 search order.
